// File: rtl/sad_pkg.sv
// Shared motion-estimation SAD types: default width, all-ones SAD marker and the
// best-match search FSM state encoding.
package sad_pkg;

    localparam int SAD_W_DFLT = 16;
    localparam logic [SAD_W_DFLT-1:0] SAD_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } sad_bm_state_t;

endpackage

// File: rtl/sad_min_cmp.sv
// Minimum-search update decision: first candidate always loads, later ones only
// on a strict improvement so ties keep the lower index.
module sad_min_cmp #(
    parameter int SAD_W = 16
) (
    input  logic [SAD_W-1:0] sad_in,
    input  logic [SAD_W-1:0] best_sad,
    input  logic             first,
    output logic             upd
);

    assign upd = first | (sad_in < best_sad);

endmodule

// File: rtl/sad_best_match.sv
// Best-match search over a window of NUM_CAND block SADs; reports min SAD and index.
// Optional threshold early termination: define SAD_BEST_MATCH_EARLY_TERM_EN.
module sad_best_match
    import sad_pkg::*;
#(
    parameter int SAD_W    = SAD_W_DFLT,
    parameter int NUM_CAND = 64,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad_in,
    input  logic [SAD_W-1:0] thresh,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic             early_term,
    output logic [IDX_W:0]   cand_cnt
);

    localparam int CNT_W = IDX_W + 1;

    sad_bm_state_t state;
    logic          accept;
    logic          first;
    logic          last;
    logic          hit;
    logic          upd;

    assign accept = (state == ST_SEARCH) && sad_valid;
    assign first  = (cand_cnt == '0);
    assign last   = (cand_cnt == CNT_W'(NUM_CAND - 1));

`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
    assign hit = (sad_in <= thresh);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign hit           = 1'b0;
`endif

    sad_min_cmp #(.SAD_W(SAD_W)) u_cmp (
        .sad_in   (sad_in),
        .best_sad (best_sad),
        .first    (first),
        .upd      (upd)
    );

    assign busy = (state == ST_SEARCH);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            best_sad   <= '1;
            best_idx   <= '0;
            cand_cnt   <= '0;
            early_term <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SEARCH;
                        best_sad   <= '1;
                        best_idx   <= '0;
                        cand_cnt   <= '0;
                        early_term <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    if (accept) begin
                        cand_cnt <= cand_cnt + CNT_W'(1);
                        if (upd) begin
                            best_sad <= sad_in;
                            best_idx <= cand_cnt[IDX_W-1:0];
                        end
                        // A threshold hit closes the window even before the last slot
                        if (hit) begin
                            early_term <= 1'b1;
                            state      <= ST_DONE;
                        end else if (last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_best_match.sv
// Directed bench for sad_best_match (NUM_CAND=4) with a done-event scoreboard.
module tb_sad_best_match;
    import sad_pkg::*;

    localparam int SAD_W    = 16;
    localparam int NUM_CAND = 4;
    localparam int IDX_W    = 2;

    typedef struct {
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] idx;
        logic [IDX_W:0]   cnt;
        logic             et;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sad_valid;
    logic [SAD_W-1:0] sad_in;
    logic [SAD_W-1:0] thresh;
    logic             busy;
    logic             done;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
    logic             early_term;
    logic [IDX_W:0]   cand_cnt;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    sad_best_match #(.SAD_W(SAD_W), .NUM_CAND(NUM_CAND), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sad_valid  (sad_valid),
        .sad_in     (sad_in),
        .thresh     (thresh),
        .busy       (busy),
        .done       (done),
        .best_sad   (best_sad),
        .best_idx   (best_idx),
        .early_term (early_term),
        .cand_cnt   (cand_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must match the oldest expected window result
    always @(negedge clk) begin
        if (done) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done cyc=%0d", cyc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++; $error("FAIL done_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
                checks++;
                assert (best_sad === e.sad) else begin
                    errors++; $error("FAIL best_sad got=%0h exp=%0h", best_sad, e.sad);
                end
                checks++;
                assert (best_idx === e.idx) else begin
                    errors++; $error("FAIL best_idx got=%0d exp=%0d", best_idx, e.idx);
                end
                checks++;
                assert (cand_cnt === e.cnt) else begin
                    errors++; $error("FAIL cand_cnt_done got=%0d exp=%0d", cand_cnt, e.cnt);
                end
                checks++;
                assert (early_term === e.et) else begin
                    errors++; $error("FAIL early_term got=%0b exp=%0b", early_term, e.et);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [SAD_W-1:0] s);
        sad_valid = 1'b1;
        sad_in    = s;
        step();
    endtask

    // Final accepted SAD of a window: done is due in the cycle after it is sampled
    task automatic send_last(input logic [SAD_W-1:0] s, input logic [SAD_W-1:0] es,
                             input logic [IDX_W-1:0] ei, input logic [IDX_W:0] ec,
                             input logic eet);
        exp_t e;
        e.sad = es; e.idx = ei; e.cnt = ec; e.et = eet; e.cyc = cyc + 1;
        sb.push_back(e);
        send(s);
    endtask

    task automatic idle(input int n);
        sad_valid = 1'b0;
        sad_in    = '0;
        repeat (n) step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sad_valid = 1'b0; sad_in = '0; thresh = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_best_sad", 32'(best_sad), 32'(SAD_MAX));
        chk("rst_best_idx", 32'(best_idx), 32'd0);
        chk("rst_early_term", 32'(early_term), 32'd0);
        chk("rst_cand_cnt", 32'(cand_cnt), 32'd0);

        // Back-to-back window with a later tie
        do_start();
        send(16'd300); send(16'd120); send(16'd500);
        send_last(16'd120, 16'd120, 2'd1, 3'd4, 1'b0);
        idle(1);
        chk("busy_after_window", 32'(busy), 32'd0);
        idle(2);
        chk("hold_best_sad", 32'(best_sad), 32'd120);

        // All-ones SADs with gaps; gap data of 0 must not be taken
        do_start();
        send(16'hFFFF); idle(1);
        chk("gap_cand_cnt", 32'(cand_cnt), 32'd1);
        send(16'hFFFF); idle(1);
        send(16'hFFFF); idle(1);
        send_last(16'hFFFF, 16'hFFFF, 2'd0, 3'd4, 1'b0);
        idle(2);

        // Reset mid-window discards it without done
        do_start();
        send(16'd5); send(16'd3);
        sad_valid = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cand_cnt", 32'(cand_cnt), 32'd0);
        chk("midrst_best_sad", 32'(best_sad), 32'(SAD_MAX));
        // Reset and start together: reset wins
        reset = 1'b1; start = 1'b1; step(); reset = 1'b0; start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        do_start();
        send(16'd9); send(16'd8); send(16'd7);
        send_last(16'd6, 16'd6, 2'd3, 3'd4, 1'b0);
        idle(2);

        // sad_valid in IDLE and start in SEARCH are ignored
        send(16'd1); send(16'd1);
        idle(1);
        chk("idle_valid_cand_cnt", 32'(cand_cnt), 32'd4);
        chk("idle_valid_busy", 32'(busy), 32'd0);
        chk("idle_valid_best", 32'(best_sad), 32'd6);
        do_start();
        send(16'd50); send(16'd60);
        start = 1'b1; send(16'd40); start = 1'b0;
        chk("start_in_search_cnt", 32'(cand_cnt), 32'd3);
        send_last(16'd70, 16'd40, 2'd2, 3'd4, 1'b0);
        idle(2);

        // Threshold stimulus; outcome depends on the early-termination build
        thresh = 16'd50;
        do_start();
        send(16'd400);
`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
        send_last(16'd40, 16'd40, 2'd1, 3'd2, 1'b1);
        send(16'd10); send(16'd70);
`else
        send(16'd40); send(16'd10);
        send_last(16'd70, 16'd10, 2'd2, 3'd4, 1'b0);
`endif
        idle(1);
        chk("thresh_busy_after", 32'(busy), 32'd0);
        idle(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
